// File: rtl/ks_adder_pipe_pkg.sv
// Shared elaboration helpers for the pipelined Kogge-Stone adder.
// Computes prefix depth, register-group count and the depth of each group.
package ks_pkg;

  // Smallest r such that 2**r >= v.
  function automatic int clog2ceil(input int v);
    int r;
    r = 0;
    for (int x = 1; x < v; x = x * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int ngrp_calc(input int levels, input int reg_every);
    return (levels + reg_every - 1) / reg_every;
  endfunction

  // The last group may hold fewer levels than reg_every.
  function automatic int grp_nlev(input int levels, input int reg_every, input int grp);
    int rem;
    rem = levels - grp * reg_every;
    return (rem < reg_every) ? rem : reg_every;
  endfunction

  function automatic int lat_calc(input int levels, input int reg_every);
    return ngrp_calc(levels, reg_every) + 2;
  endfunction

endpackage

// File: rtl/ks_adder_pipe_prefix_group.sv
// Combinational block of NLEV consecutive Kogge-Stone prefix levels,
// starting at level START (span 2**START).
module ks_prefix_group #(
  parameter int WIDTH = 32,
  parameter int START = 0,
  parameter int NLEV  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  logic [WIDTH-1:0] g_lvl [NLEV+1];
  logic [WIDTH-1:0] p_lvl [NLEV+1];

  assign g_lvl[0] = g_in;
  assign p_lvl[0] = p_in;

  genvar gi;
  generate
    for (gi = 0; gi < NLEV; gi++) begin : g_level
      localparam int D = 1 << (START + gi);
      // Bits below the span keep their propagate; the shifted-in zeros
      // already leave their generate untouched.
      localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << D) - WIDTH'(1);
      assign g_lvl[gi+1] = g_lvl[gi] | (p_lvl[gi] & (g_lvl[gi] << D));
      assign p_lvl[gi+1] = p_lvl[gi] & ((p_lvl[gi] << D) | LOW_MASK);
    end
  endgenerate

  assign g_out = g_lvl[NLEV];
  assign p_out = p_lvl[NLEV];

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready flow control and global stall.
// Optional subtract input i_sub is enabled by defining KS_ADDER_PIPE_SUB_EN.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
`ifdef KS_ADDER_PIPE_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int LEVELS = clog2ceil(WIDTH);
  localparam int NGRP   = ngrp_calc(LEVELS, REG_EVERY);
  localparam int LAT    = lat_calc(LEVELS, REG_EVERY);

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] gp;
    logic             c0;
    logic             valid;
  } ks_pg_t;

  // Slot 0 is the p/g register, slots 1..NGRP follow each prefix group;
  // the output register completes the LAT stages.
  ks_pg_t           stage_reg [LAT-1];
  ks_pg_t           stage0_next;
  logic [WIDTH-1:0] grp_g  [NGRP];
  logic [WIDTH-1:0] grp_gp [NGRP];
  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  logic [WIDTH-1:0] sum_next;
  logic             en;

  assign en      = !o_valid | i_ready;
  assign o_ready = en;

`ifdef KS_ADDER_PIPE_SUB_EN
  assign b_eff  = i_sub ? ~i_b : i_b;
  assign c0_eff = i_c0 | i_sub;
`else
  assign b_eff  = i_b;
  assign c0_eff = i_c0;
`endif

  // Carry-in is folded into bit 0 generate so the prefix tree needs no extra column.
  always_comb begin
    stage0_next       = '0;
    stage0_next.p     = i_a ^ b_eff;
    stage0_next.g     = i_a & b_eff;
    stage0_next.g[0]  = stage0_next.g[0] | (stage0_next.p[0] & c0_eff);
    stage0_next.gp    = stage0_next.p;
    stage0_next.c0    = c0_eff;
    stage0_next.valid = i_valid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      ks_prefix_group #(
        .WIDTH(WIDTH),
        .START(gi * REG_EVERY),
        .NLEV (grp_nlev(LEVELS, REG_EVERY, gi))
      ) u_grp (
        .g_in (stage_reg[gi].g),
        .p_in (stage_reg[gi].gp),
        .g_out(grp_g[gi]),
        .p_out(grp_gp[gi])
      );
    end
  endgenerate

  assign sum_next = stage_reg[NGRP].p ^ {stage_reg[NGRP].g[WIDTH-2:0], stage_reg[NGRP].c0};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= NGRP; k++) begin
        stage_reg[k] <= '0;
      end
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (en) begin
      stage_reg[0] <= stage0_next;
      for (int k = 0; k < NGRP; k++) begin
        stage_reg[k+1].p     <= stage_reg[k].p;
        stage_reg[k+1].g     <= grp_g[k];
        stage_reg[k+1].gp    <= grp_gp[k];
        stage_reg[k+1].c0    <= stage_reg[k].c0;
        stage_reg[k+1].valid <= stage_reg[k].valid;
      end
      o_valid <= stage_reg[NGRP].valid;
      o_sum   <= sum_next;
      o_cout  <= stage_reg[NGRP].g[WIDTH-1];
      o_ovf   <= stage_reg[NGRP].g[WIDTH-2] ^ stage_reg[NGRP].g[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe: a 32-bit/REG_EVERY=1 instance and a
// 16-bit/REG_EVERY=4 instance, checked against an arithmetic reference model.
module tb_ks_adder_pipe;

  localparam int LAT32 = 7;
  localparam int LAT16 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v32 = 1'b0, rdy32, ov32, ir32 = 1'b1, c32 = 1'b0, cout32, ovf32;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        v16 = 1'b0, rdy16, ov16, ir16 = 1'b1, c16 = 1'b0, cout16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
`ifdef KS_ADDER_PIPE_SUB_EN
  logic        sub32 = 1'b0, sub16 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  always #5 clk = ~clk;

  ks_adder_pipe #(.WIDTH(32), .REG_EVERY(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(rdy32),
    .i_a(a32), .i_b(b32), .i_c0(c32),
`ifdef KS_ADDER_PIPE_SUB_EN
    .i_sub(sub32),
`endif
    .o_valid(ov32), .i_ready(ir32), .o_sum(sum32), .o_cout(cout32), .o_ovf(ovf32)
  );

  ks_adder_pipe #(.WIDTH(16), .REG_EVERY(4)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(rdy16),
    .i_a(a16), .i_b(b16), .i_c0(c16),
`ifdef KS_ADDER_PIPE_SUB_EN
    .i_sub(sub16),
`endif
    .o_valid(ov16), .i_ready(ir16), .o_sum(sum16), .o_cout(cout16), .o_ovf(ovf16)
  );

  // Reference: plain wide arithmetic; subtraction as a + ~b + 1.
  function automatic void ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic c0, input logic sub,
                                  output logic [63:0] sum, output logic cout, output logic ovf);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] bb;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? (~b & mask) : (b & mask);
    full = {1'b0, a & mask} + {1'b0, bb} + 65'(c0 | sub);
    sum  = full[63:0] & mask;
    cout = full[w];
    ovf  = (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_valid32 got=%b exp=0", ov32); end
    checks++; if (sum32 !== 32'h0) begin errors++; $display("FAIL reset_sum32 got=%h exp=0", sum32); end
    checks++; if ({cout32, ovf32} !== 2'b00) begin errors++; $display("FAIL reset_flags32 got=%b exp=00", {cout32, ovf32}); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_valid16 got=%b exp=0", ov16); end
    checks++; if (sum16 !== 16'h0) begin errors++; $display("FAIL reset_sum16 got=%h exp=0", sum16); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_ready32 got=%b exp=1", rdy32); end
    checks++; if (rdy16 !== 1'b1) begin errors++; $display("FAIL reset_ready16 got=%b exp=1", rdy16); end
  endtask

  task automatic test_directed32();
    logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0};
    logic [31:0] tb [3] = '{32'h1, 32'h1, 32'h0};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] es [3] = '{32'h0, 32'h8000_0000, 32'h1};
    logic        ec [3] = '{1'b1, 1'b0, 1'b0};
    logic        eo [3] = '{1'b0, 1'b1, 1'b0};
    int cnt;
    bit got;
    ir32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v32 = 1'b1; a32 = ta[i]; b32 = tb[i]; c32 = tc[i];
      cnt = 0; got = 0;
      while (cnt < 20) begin
        @(posedge clk); @(negedge clk);
        v32 = 1'b0;
        cnt++;
        if (ov32 === 1'b1) begin got = 1; break; end
      end
      $display("txn dir32 a=%h b=%h c0=%b -> sum=%h cout=%b ovf=%b lat=%0d", ta[i], tb[i], tc[i], sum32, cout32, ovf32, cnt);
      checks++; if (!got || cnt != LAT32) begin errors++; $display("FAIL dir32_latency[%0d] got=%0d exp=%0d", i, cnt, LAT32); end
      checks++; if (sum32 !== es[i]) begin errors++; $display("FAIL dir32_sum[%0d] got=%h exp=%h", i, sum32, es[i]); end
      checks++; if (cout32 !== ec[i]) begin errors++; $display("FAIL dir32_cout[%0d] got=%b exp=%b", i, cout32, ec[i]); end
      checks++; if (ovf32 !== eo[i]) begin errors++; $display("FAIL dir32_ovf[%0d] got=%b exp=%b", i, ovf32, eo[i]); end
    end
  endtask

  task automatic test_width16();
    int cnt;
    bit got;
    ir16 = 1'b1;
    @(negedge clk);
    v16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000; c16 = 1'b1;
    cnt = 0; got = 0;
    while (cnt < 20) begin
      @(posedge clk); @(negedge clk);
      v16 = 1'b0;
      cnt++;
      if (ov16 === 1'b1) begin got = 1; break; end
    end
    $display("txn w16 a=8000 b=8000 c0=1 -> sum=%h cout=%b ovf=%b lat=%0d", sum16, cout16, ovf16, cnt);
    checks++; if (!got || cnt != LAT16) begin errors++; $display("FAIL w16_latency got=%0d exp=%0d", cnt, LAT16); end
    checks++; if (sum16 !== 16'h0001) begin errors++; $display("FAIL w16_sum got=%h exp=0001", sum16); end
    checks++; if (cout16 !== 1'b1) begin errors++; $display("FAIL w16_cout got=%b exp=1", cout16); end
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL w16_ovf got=%b exp=1", ovf16); end
  endtask

`ifdef KS_ADDER_PIPE_SUB_EN
  task automatic test_sub();
    int cnt;
    bit got;
    ir32 = 1'b1;
    @(negedge clk);
    v32 = 1'b1; a32 = 32'h5; b32 = 32'h7; c32 = 1'b0; sub32 = 1'b1;
    cnt = 0; got = 0;
    while (cnt < 20) begin
      @(posedge clk); @(negedge clk);
      v32 = 1'b0; sub32 = 1'b0;
      cnt++;
      if (ov32 === 1'b1) begin got = 1; break; end
    end
    $display("txn sub32 a=5 b=7 -> sum=%h cout=%b ovf=%b lat=%0d", sum32, cout32, ovf32, cnt);
    checks++; if (!got || cnt != LAT32) begin errors++; $display("FAIL sub_latency got=%0d exp=%0d", cnt, LAT32); end
    checks++; if (sum32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_sum got=%h exp=fffffffe", sum32); end
    checks++; if ({cout32, ovf32} !== 2'b00) begin errors++; $display("FAIL sub_flags got=%b exp=00", {cout32, ovf32}); end
  endtask
`endif

  task automatic test_back_to_back();
    exp_t        exp_q [$];
    exp_t        e;
    exp_t        h;
    logic [63:0] s;
    logic        co, ov, sb;
    int sent, cyc;
    bit pend, extra;
    sent = 0; cyc = 0; pend = 0;
    while ((sent < 100 || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        if (sent < 100 && $urandom_range(0, 3) != 0) begin
          a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(0, 1));
`ifdef KS_ADDER_PIPE_SUB_EN
          sub32 = 1'($urandom_range(0, 1));
`endif
          v32 = 1'b1; pend = 1;
        end else begin
          v32 = 1'b0;
        end
      end
      ir32 = (sent >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (rdy32 !== (!ov32 || ir32)) begin
        errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, rdy32, !ov32 || ir32);
      end
      if (ov32 === 1'b1 && ir32) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_result got=%h exp=none", sum32);
        end else begin
          h = exp_q.pop_front();
          $display("txn b2b a=%h b=%h -> sum=%h cout=%b ovf=%b", h.a, h.b, sum32, cout32, ovf32);
          if ({sum32, cout32, ovf32} !== {h.sum, h.cout, h.ovf}) begin
            errors++;
            $display("FAIL b2b_result got=%h/%b/%b exp=%h/%b/%b", sum32, cout32, ovf32, h.sum, h.cout, h.ovf);
          end
        end
      end
      if (v32 && rdy32 === 1'b1) begin
        sb = 1'b0;
`ifdef KS_ADDER_PIPE_SUB_EN
        sb = sub32;
`endif
        ref_add(32, {32'h0, a32}, {32'h0, b32}, c32, sb, s, co, ov);
        e.a = a32; e.b = b32; e.sum = s[31:0]; e.cout = co; e.ovf = ov;
        exp_q.push_back(e);
        sent++;
        pend = 0;
      end
    end
    @(negedge clk);
    v32 = 1'b0;
`ifdef KS_ADDER_PIPE_SUB_EN
    sub32 = 1'b0;
`endif
    checks++; if (exp_q.size() != 0 || sent != 100) begin errors++; $display("FAIL b2b_lost got=%0d pending sent=%0d exp=0 pending 100 sent", exp_q.size(), sent); end
    extra = 0;
    repeat (LAT32 + 2) begin
      @(negedge clk);
      if (ov32 !== 1'b0) extra = 1;
    end
    checks++; if (extra) begin errors++; $display("FAIL b2b_duplicate got=valid exp=idle"); end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] s;
    logic        co, ov;
    logic [31:0] na, nb;
    int cnt;
    bit got, extra;
    ir32 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      v32 = 1'b1; a32 = $urandom; b32 = $urandom; c32 = 1'b1;
    end
    @(negedge clk);
    checks++; if (ov32 !== 1'b1 || rdy32 !== 1'b0) begin errors++; $display("FAIL full_stall got=v%b r%b exp=v1 r0", ov32, rdy32); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL async_reset_valid got=%b exp=0", ov32); end
    checks++; if (sum32 !== 32'h0) begin errors++; $display("FAIL async_reset_sum got=%h exp=0", sum32); end
    @(negedge clk);
    v32 = 1'b0; rst_n = 1'b1; ir32 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (rdy32 !== 1'b1 || ov32 !== 1'b0) begin errors++; $display("FAIL post_reset got=r%b v%b exp=r1 v0", rdy32, ov32); end
    na = $urandom; nb = $urandom;
    ref_add(32, {32'h0, na}, {32'h0, nb}, 1'b0, 1'b0, s, co, ov);
    v32 = 1'b1; a32 = na; b32 = nb; c32 = 1'b0;
    cnt = 0; got = 0;
    while (cnt < 20) begin
      @(posedge clk); @(negedge clk);
      v32 = 1'b0;
      cnt++;
      if (ov32 === 1'b1) begin got = 1; break; end
    end
    $display("txn post_reset a=%h b=%h -> sum=%h cout=%b ovf=%b lat=%0d", na, nb, sum32, cout32, ovf32, cnt);
    checks++; if (!got || cnt != LAT32) begin errors++; $display("FAIL post_reset_latency got=%0d exp=%0d", cnt, LAT32); end
    checks++; if ({sum32, cout32, ovf32} !== {s[31:0], co, ov}) begin errors++; $display("FAIL post_reset_result got=%h/%b/%b exp=%h/%b/%b", sum32, cout32, ovf32, s[31:0], co, ov); end
    extra = 0;
    repeat (LAT32 + 2) begin
      @(negedge clk);
      if (ov32 !== 1'b0) extra = 1;
    end
    checks++; if (extra) begin errors++; $display("FAIL post_reset_stale got=valid exp=idle"); end
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_width16();
`ifdef KS_ADDER_PIPE_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
